// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer_if
// Description : Switch bank bus: raw inputs in, debounced levels and edge
//               pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             changed;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  changed
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output changed
    );
endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Per-bit two-flop synchroniser and stability counter producing
//               debounced switch levels plus one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic              clk,
    input  logic              reset,
    switch_debouncer_if.slave sw_bus
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     r_sync1;
    logic [WIDTH-1:0]     r_sync2;
    logic [WIDTH-1:0]     r_clean;
    logic [WIDTH-1:0]     r_rise;
    logic [WIDTH-1:0]     r_fall;
    logic                 r_changed;
    logic [CNT_WIDTH-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0]     w_clean_next;
    logic [WIDTH-1:0]     w_rise_next;
    logic [WIDTH-1:0]     w_fall_next;
    logic                 w_changed_next;
    logic [CNT_WIDTH-1:0] w_cnt_next [WIDTH];

    // A bit flips only once the synchronised level has disagreed with the
    // clean level for STABLE_CYCLES consecutive edges; any agreement restarts.
    always_comb begin
        w_clean_next = r_clean;
        w_rise_next  = '0;
        w_fall_next  = '0;
        w_cnt_next   = r_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_clean[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == C_CNT_MAX) begin
                w_cnt_next[i]   = '0;
                w_clean_next[i] = r_sync2[i];
                w_rise_next[i]  = r_sync2[i];
                w_fall_next[i]  = ~r_sync2[i];
            end else begin
                w_cnt_next[i] = r_cnt[i] + C_CNT_ONE;
            end
        end
    end

    assign w_changed_next = |(w_rise_next | w_fall_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_clean   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= sw_bus.sw_raw;
            r_sync2   <= r_sync1;
            r_clean   <= w_clean_next;
            r_rise    <= w_rise_next;
            r_fall    <= w_fall_next;
            r_changed <= w_changed_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign sw_bus.sw_clean = r_clean;
    assign sw_bus.sw_rise  = r_rise;
    assign sw_bus.sw_fall  = r_fall;
    assign sw_bus.changed  = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed and random checks of switch_debouncer against a
//               sliding-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int CW    = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(WIDTH)) sw_bus ();

    switch_debouncer #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (N),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_bus (sw_bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: a bit flips when the last N pre-edge synchronised samples
    // since reset all disagree with the current clean level.
    logic [7:0] m_s1      = '0;
    logic [7:0] m_s2      = '0;
    logic [7:0] m_clean   = '0;
    logic [7:0] m_rise    = '0;
    logic [7:0] m_fall    = '0;
    logic [7:0] m_changed = '0;
    logic [7:0] hist[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit all_diff;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0;
            m_rise = '0; m_fall = '0; m_changed = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                all_diff = (hist.size() == N);
                foreach (hist[k]) if (hist[k][i] == m_clean[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_clean[i] = ~m_clean[i];
                    if (m_clean[i]) m_rise[i] = 1'b1;
                    else            m_fall[i] = 1'b1;
                end
            end
            m_changed = {7'b0, |(m_rise | m_fall)};
            m_s2 = m_s1;
            m_s1 = sw_bus.sw_raw;
        end
    endtask

    task automatic cycle(input logic [7:0] raw, input logic rst);
        sw_bus.sw_raw = raw;
        reset         = rst;
        @(posedge clk);
        model_edge();
        #1;
        check("clean",   sw_bus.sw_clean,        m_clean);
        check("rise",    sw_bus.sw_rise,         m_rise);
        check("fall",    sw_bus.sw_fall,         m_fall);
        check("changed", {7'b0, sw_bus.changed}, m_changed);
        @(negedge clk);
    endtask

    logic [7:0] r_raw;
    logic [7:0] mask;
    logic       pulse3;
    int         hi_prob;

    initial begin
        sw_bus.sw_raw = '0;
        @(negedge clk);

        // Reset with all switches high, then release
        cycle(8'hFF, 1'b1);
        cycle(8'hFF, 1'b1);
        check("rst_clean",   sw_bus.sw_clean,        8'h00);
        check("rst_rise",    sw_bus.sw_rise,         8'h00);
        check("rst_changed", {7'b0, sw_bus.changed}, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            cycle(8'hFF, 1'b0);
            if (k == 5) check("rel_clean_early", sw_bus.sw_clean, 8'h00);
            if (k == 6) begin
                check("rel_clean",   sw_bus.sw_clean,        8'hFF);
                check("rel_rise",    sw_bus.sw_rise,         8'hFF);
                check("rel_changed", {7'b0, sw_bus.changed}, 8'h01);
            end
            if (k == 7) check("rel_rise_end", sw_bus.sw_rise, 8'h00);
        end

        // Clean step on bit 0
        for (int k = 0; k < 8; k++) cycle(8'h00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            cycle(8'h01, 1'b0);
            if (k == 5) check("step_early", sw_bus.sw_clean, 8'h00);
            if (k == 6) begin
                check("step_clean", sw_bus.sw_clean, 8'h01);
                check("step_rise",  sw_bus.sw_rise,  8'h01);
            end
            if (k == 7) check("step_rise_end", sw_bus.sw_rise, 8'h00);
            check("step_fall", sw_bus.sw_fall, 8'h00);
        end

        // Bounce on bit 3: 2-cycle toggles, then 3-cycle highs
        pulse3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(((k / 2) % 2 == 0) ? 8'h09 : 8'h01, 1'b0);
            pulse3 |= sw_bus.sw_rise[3] | sw_bus.sw_fall[3];
        end
        for (int k = 0; k < 10; k++) begin
            cycle((k % 5 < 3) ? 8'h09 : 8'h01, 1'b0);
            pulse3 |= sw_bus.sw_rise[3] | sw_bus.sw_fall[3];
        end
        for (int k = 0; k < 8; k++) begin
            cycle(8'h01, 1'b0);
            pulse3 |= sw_bus.sw_rise[3] | sw_bus.sw_fall[3];
        end
        check("bounce_clean3", {7'b0, sw_bus.sw_clean[3]}, 8'h00);
        check("bounce_pulse3", {7'b0, pulse3},             8'h00);

        // Debounced release of bit 5
        for (int k = 0; k < 8; k++) cycle(8'h21, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            cycle(8'h01, 1'b0);
            if (k == 5) check("release_early", sw_bus.sw_clean, 8'h21);
            if (k == 6) begin
                check("release_clean", sw_bus.sw_clean, 8'h01);
                check("release_fall",  sw_bus.sw_fall,  8'h20);
            end
            if (k == 7) check("release_fall_end", sw_bus.sw_fall, 8'h00);
        end

        // Simultaneous flips
        for (int k = 0; k < 8; k++) cycle(8'h00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            cycle(8'hA5, 1'b0);
            if (k == 6) begin
                check("simul_clean",   sw_bus.sw_clean,        8'hA5);
                check("simul_rise",    sw_bus.sw_rise,         8'hA5);
                check("simul_changed", {7'b0, sw_bus.changed}, 8'h01);
            end
            if (k == 7) check("simul_changed_end", {7'b0, sw_bus.changed}, 8'h00);
        end

        // Reset while bit 7 is mid-count
        for (int k = 0; k < 8; k++) cycle(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) cycle(8'h80, 1'b0);
        cycle(8'h80, 1'b1);
        check("midrst_clean", sw_bus.sw_clean, 8'h00);
        check("midrst_rise",  sw_bus.sw_rise,  8'h00);
        for (int k = 1; k <= 6; k++) begin
            cycle(8'h80, 1'b0);
            if (k == 5) check("midrst_early", sw_bus.sw_clean, 8'h00);
            if (k == 6) begin
                check("midrst_clean_after", sw_bus.sw_clean, 8'h80);
                check("midrst_rise_after",  sw_bus.sw_rise,  8'h80);
            end
        end

        // Random phases alternating bouncy and calm inputs, rare resets
        r_raw = 8'h80;
        for (int k = 0; k < 600; k++) begin
            hi_prob = ((k / 40) % 2 == 0) ? 2 : 12;
            mask = '0;
            for (int b = 0; b < WIDTH; b++)
                mask[b] = ($urandom_range(0, hi_prob) == 0);
            r_raw ^= mask;
            cycle(r_raw, ($urandom_range(0, 149) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
